cache_fill_fsm: RTL and testbench

CACHE_FILL_FSM -- requirements
Module: cache_fill_fsm

---
 rtl/cache_fill_fsm_pkg.sv | 17 +
 rtl/cache_fill_fsm_counter.sv | 37 +++
 rtl/cache_fill_fsm.sv | 122 ++++++++++++
 tb/tb_cache_fill_fsm.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_fill_fsm_pkg.sv
// Shared definitions for the cache block fill controller.
//   state_t     : fill controller state encoding (IDLE=0, FILL=1)
//   BLOCK_WORDS : 16-bit words per cache block
//   WORD_OFF_W  : width of the word offset within a block
//   CNT_W       : width of the request/receive counters (range 0..BLOCK_WORDS)
package cache_fill_fsm_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_t;

  localparam int unsigned BLOCK_WORDS = 8;
  localparam int unsigned WORD_OFF_W  = 3;
  localparam int unsigned CNT_W       = 4;

endpackage

// File: rtl/cache_fill_fsm_counter.sv
// Saturating up-counter used to track issued requests and received words.
//   clk, rst : clock, asynchronous active-high reset
//   clr      : synchronous clear to zero (wins over inc)
//   inc      : increment enable; the count holds once it reaches MAX_VAL
//   cnt      : current count
module fill_counter #(
  parameter logic [cache_fill_fsm_pkg::CNT_W-1:0] MAX_VAL = 4'd8
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  clr,
  input  logic                                  inc,
  output logic [cache_fill_fsm_pkg::CNT_W-1:0]  cnt
);

  logic [cache_fill_fsm_pkg::CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q < MAX_VAL)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/cache_fill_fsm.sv
// Cache miss block-fill controller. On a miss it requests every word of the
// missing block from pipelined main memory, writes each returned word into
// the data array, and pulses the tag write alongside the last word.
//   clk, rst          : clock, asynchronous active-high reset
//   miss_detected     : lookup missed; held by the requester until fsm_busy falls
//   miss_address      : byte address of the missed access
//   memory_data       : word returned by memory (routed to the data array externally)
//   memory_data_valid : memory_data is valid this cycle
//   fsm_busy          : fill in progress (registered state only)
//   memory_read_en    : read request at memory_address this cycle
//   memory_address    : word-aligned request address
//   write_data_array  : write memory_data at data_word_idx this cycle
//   data_word_idx     : word offset of the current data write
//   write_tag_array   : one-cycle tag/valid write for the filled block
module cache_fill_fsm #(
  parameter int unsigned BLOCK_WORDS = 8,
  parameter int unsigned ADDR_W      = 16
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       miss_detected,
  input  logic [ADDR_W-1:0]                          miss_address,
  input  logic [15:0]                                memory_data,
  input  logic                                       memory_data_valid,
  output logic                                       fsm_busy,
  output logic                                       memory_read_en,
  output logic [ADDR_W-1:0]                          memory_address,
  output logic                                       write_data_array,
  output logic [cache_fill_fsm_pkg::WORD_OFF_W-1:0]  data_word_idx,
  output logic                                       write_tag_array
);

  import cache_fill_fsm_pkg::*;

  // Byte offset within a block: word offset plus the byte-in-word bit.
  localparam int unsigned           OFF_W    = WORD_OFF_W + 1;
  localparam int unsigned           BASE_W   = ADDR_W - OFF_W;
  localparam logic [CNT_W-1:0]      CNT_MAX  = CNT_W'(BLOCK_WORDS);
  localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(BLOCK_WORDS - 1);

  state_t              state_q, state_d;
  logic [BASE_W-1:0]   base_q, base_d;
  logic [CNT_W-1:0]    req_cnt, recv_cnt;
  logic                cnt_clr, req_inc, recv_inc;

  // Data passes straight to the data array; the low address bits select
  // within the block and are irrelevant to the fill.
  logic unused_inputs;
  assign unused_inputs = ^{memory_data, miss_address[OFF_W-1:0]};

  fill_counter #(.MAX_VAL(CNT_MAX)) u_req_cnt (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .inc (req_inc),
    .cnt (req_cnt)
  );

  fill_counter #(.MAX_VAL(CNT_MAX)) u_recv_cnt (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .inc (recv_inc),
    .cnt (recv_cnt)
  );

  always_comb begin
    state_d          = state_q;
    base_d           = base_q;
    cnt_clr          = 1'b0;
    req_inc          = 1'b0;
    recv_inc         = 1'b0;
    fsm_busy         = 1'b0;
    memory_read_en   = 1'b0;
    memory_address   = '0;
    write_data_array = 1'b0;
    data_word_idx    = '0;
    write_tag_array  = 1'b0;

    case (state_q)
      IDLE: begin
        if (miss_detected) begin
          state_d = FILL;
          base_d  = miss_address[ADDR_W-1:OFF_W];
          cnt_clr = 1'b1;
        end
      end

      FILL: begin
        fsm_busy = 1'b1;
        if (req_cnt < CNT_MAX) begin
          memory_read_en = 1'b1;
          memory_address = {base_q, req_cnt[WORD_OFF_W-1:0], 1'b0};
          req_inc        = 1'b1;
        end
        // Returns are in request order, so the receive count is the word index.
        if (memory_data_valid && (recv_cnt < CNT_MAX)) begin
          write_data_array = 1'b1;
          data_word_idx    = recv_cnt[WORD_OFF_W-1:0];
          recv_inc         = 1'b1;
          if (recv_cnt == CNT_LAST) begin
            write_tag_array = 1'b1;
            state_d         = IDLE;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      base_q  <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
    end
  end

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Randomised scoreboard bench for cache_fill_fsm. The driver runs a
// transaction-level model of the fill (cycle n of a fill requests word n-1,
// memory answers each request L cycles later in order, the k-th accepted word
// goes to index k) and queues one expected output record per cycle; a separate
// monitor pops and compares on the falling edge.
module tb_cache_fill_fsm;

  localparam int L = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        miss_detected;
  logic [15:0] miss_address;
  logic [15:0] memory_data;
  logic        memory_data_valid;
  logic        fsm_busy;
  logic        memory_read_en;
  logic [15:0] memory_address;
  logic        write_data_array;
  logic [2:0]  data_word_idx;
  logic        write_tag_array;

  always #5 clk = ~clk;

  cache_fill_fsm #(.BLOCK_WORDS(8), .ADDR_W(16)) dut (
    .clk               (clk),
    .rst               (rst),
    .miss_detected     (miss_detected),
    .miss_address      (miss_address),
    .memory_data       (memory_data),
    .memory_data_valid (memory_data_valid),
    .fsm_busy          (fsm_busy),
    .memory_read_en    (memory_read_en),
    .memory_address    (memory_address),
    .write_data_array  (write_data_array),
    .data_word_idx     (data_word_idx),
    .write_tag_array   (write_tag_array)
  );

  typedef struct {
    int cyc;
    bit busy;
    bit rd;
    int addr;
    bit wr;
    int idx;
    bit tag;
  } exp_t;

  typedef struct {
    int addr;
    int due;
  } mreq_t;

  exp_t  exp_q[$];
  mreq_t mem_q[$];

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Reference model state
  bit m_fill;
  int m_fc;
  int m_recv;
  int m_base;
  // Memory stub controls
  int mem_words;
  int stall_word = -1;
  int stall_left = 0;
  int rand_stall_pct = 0;

  task automatic chk(input string name, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s (cycle %0d): got %0h expected %0h", name, cyc, act, exp_v);
    end
  endtask

  function automatic logic [15:0] mem_word(input int a);
    return 16'(a) ^ 16'h5A3C;
  endfunction

  task automatic model_clear();
    m_fill = 1'b0;
    m_fc = 0;
    m_recv = 0;
    mem_q.delete();
    stall_word = -1;
    stall_left = 0;
  endtask

  // One clock cycle: drive inputs, queue the expected outputs, advance model.
  task automatic tick(input bit miss, input logic [15:0] maddr, input bit spurious);
    exp_t e;
    bit v;
    logic [15:0] d;
    @(posedge clk);
    #1;
    cyc++;
    v = 1'b0;
    d = 16'($urandom);
    if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      if (stall_left > 0 && mem_words == stall_word) begin
        stall_left--;
      end else if (int'($urandom_range(99)) < rand_stall_pct) begin
        v = 1'b0;
      end else begin
        v = 1'b1;
        d = mem_word(mem_q[0].addr);
        void'(mem_q.pop_front());
        mem_words++;
      end
    end else if (spurious) begin
      v = 1'b1;
    end
    miss_detected     = miss;
    miss_address      = maddr;
    memory_data_valid = v;
    memory_data       = d;

    e.cyc  = cyc;
    e.busy = m_fill;
    e.rd   = m_fill && m_fc >= 1 && m_fc <= 8;
    e.addr = e.rd ? (m_base * 16 + (m_fc - 1) * 2) : 0;
    e.wr   = m_fill && v && m_recv < 8;
    e.idx  = e.wr ? m_recv : 0;
    e.tag  = e.wr && m_recv == 7;
    exp_q.push_back(e);

    if (!m_fill) begin
      if (miss) begin
        m_fill    = 1'b1;
        m_base    = int'(maddr) / 16;
        m_fc      = 1;
        m_recv    = 0;
        mem_words = 0;
      end
    end else begin
      if (e.rd) mem_q.push_back('{e.addr, cyc + L});
      m_fc++;
      if (e.wr) begin
        m_recv++;
        if (m_recv == 8) m_fill = 1'b0;
      end
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_busy"}, int'(fsm_busy), 0);
    chk({tag, "_rd"},   int'(memory_read_en), 0);
    chk({tag, "_addr"}, int'(memory_address), 0);
    chk({tag, "_wr"},   int'(write_data_array), 0);
    chk({tag, "_idx"},  int'(data_word_idx), 0);
    chk({tag, "_tag"},  int'(write_tag_array), 0);
  endtask

  // Reset asserted mid-cycle; outputs must drop without waiting for an edge.
  task automatic do_reset();
    @(posedge clk);
    #2;
    rst = 1'b1;
    miss_detected = 1'b0;
    memory_data_valid = 1'b0;
    #1;
    check_outputs_zero("async_reset");
    model_clear();
    tick(1'b0, 16'h0, 1'b0);
    tick(1'b0, 16'h0, 1'b0);
    rst = 1'b0;
  endtask

  // Requester holds miss_detected until cycle drop_at of the fill (or until
  // busy falls), scribbling on miss_address meanwhile.
  task automatic run_fill(input logic [15:0] addr, input int drop_at,
                          input int st_word, input int st_len);
    int n;
    stall_word = st_word;
    stall_left = st_len;
    tick(1'b1, addr, 1'b0);
    n = 0;
    while (m_fill && n < 100) begin
      n++;
      tick(n < drop_at, 16'($urandom), 1'b0);
    end
    if (n >= 100) chk("fill_timeout", 1, 0);
    stall_word = -1;
    stall_left = 0;
  endtask

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("fsm_busy",         int'(fsm_busy),         int'(e.busy));
        chk("memory_read_en",   int'(memory_read_en),   int'(e.rd));
        chk("memory_address",   int'(memory_address),   e.addr);
        chk("write_data_array", int'(write_data_array), int'(e.wr));
        chk("data_word_idx",    int'(data_word_idx),    e.idx);
        chk("write_tag_array",  int'(write_tag_array),  int'(e.tag));
      end else if (!rst) begin
        chk("unexpected_strobe",
            int'(memory_read_en | write_data_array | write_tag_array), 0);
      end
    end
  end

  // Driver
  initial begin
    int n;
    rst = 1'b1;
    miss_detected = 1'b0;
    miss_address = '0;
    memory_data = '0;
    memory_data_valid = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    check_outputs_zero("reset_state");
    rst = 1'b0;

    // Valid strobes while idle must be ignored.
    repeat (3) tick(1'b0, 16'h0, 1'b1);

    // Basic fill at 0x1236, then a stray ninth valid.
    run_fill(16'h1236, 1000, -1, 0);
    tick(1'b0, 16'h0, 1'b1);
    tick(1'b0, 16'h0, 1'b0);

    // Two-cycle gap between words 3 and 4.
    run_fill(16'h2468, 1000, 4, 2);
    tick(1'b0, 16'h0, 1'b0);

    // Reset after the fifth word, then a clean fill at 0x00F0.
    tick(1'b1, 16'h3ABC, 1'b0);
    n = 0;
    while (m_recv < 5 && n < 100) begin
      n++;
      tick(1'b1, 16'($urandom), 1'b0);
    end
    if (n >= 100) chk("reset_fill_timeout", 1, 0);
    do_reset();
    run_fill(16'h00F0, 1000, -1, 0);
    tick(1'b0, 16'h0, 1'b0);

    // Back-to-back: miss held high through completion with a new address.
    tick(1'b1, 16'h4000, 1'b0);
    n = 0;
    while (m_fill && n < 100) begin
      n++;
      tick(1'b1, 16'h4000, 1'b0);
    end
    if (n >= 100) chk("b2b_timeout", 1, 0);
    run_fill(16'h8002, 1000, -1, 0);
    tick(1'b0, 16'h0, 1'b0);

    // Requester drops miss in fill cycle 2.
    run_fill(16'h5554, 2, -1, 0);
    tick(1'b0, 16'h0, 1'b0);

    // Randomised fills with idle noise, random gaps and drop points.
    rand_stall_pct = 25;
    for (int i = 0; i < 20; i++) begin
      repeat ($urandom_range(3)) tick(1'b0, 16'($urandom), 1'($urandom_range(1)));
      run_fill(16'($urandom), int'($urandom_range(1, 15)),
               int'($urandom_range(7)), int'($urandom_range(3)));
      tick(1'b0, 16'h0, 1'($urandom_range(1)));
    end
    rand_stall_pct = 0;

    tick(1'b0, 16'h0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    #1;
    if (exp_q.size() != 0) chk("scoreboard_drain", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
